// File: rtl/note_player.sv
// note_player: square-wave tone generator for the music box bell pin.
//
// Accepts one note at a time over note_valid/note_ready, sounds the note's
// equal-tempered pitch as a square wave on bell for note_len duration units
// (0 counts as 1), then holds bell low for GAP_TICKS silent units before it
// accepts the next note. Pitch 0 and 22..31 are rests (bell stays low).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   note_valid  in   sequencer presents a note
//   note_ready  out  player can accept a note (IDLE and not in reset)
//   note_pitch  in   0 rest, 1..21 = C3..B5 naturals, 22..31 rest
//   note_len    in   duration in units
//   bell        out  square-wave speaker drive
//   busy        out  high while playing or in the articulation gap
//   cur_pitch   out  latched pitch while busy, 0 when idle
module note_player #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [4:0] note_pitch,
    input  logic [3:0] note_len,
    output logic       bell,
    output logic       busy,
    output logic [4:0] cur_pitch
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0]     GAP_UNITS = 16'(GAP_TICKS);

    // Half-period in cycles at 100 MHz; C3 and B5 use the music box's
    // reference tuning values.
    function automatic longint base_half(input logic [4:0] p);
        case (p)
            5'd1:    return 64'd382234;
            5'd2:    return 64'd340524;
            5'd3:    return 64'd303373;
            5'd4:    return 64'd286346;
            5'd5:    return 64'd255105;
            5'd6:    return 64'd227273;
            5'd7:    return 64'd202477;
            5'd8:    return 64'd191113;
            5'd9:    return 64'd170262;
            5'd10:   return 64'd151686;
            5'd11:   return 64'd143173;
            5'd12:   return 64'd127553;
            5'd13:   return 64'd113636;
            5'd14:   return 64'd101238;
            5'd15:   return 64'd95556;
            5'd16:   return 64'd85131;
            5'd17:   return 64'd75843;
            5'd18:   return 64'd71586;
            5'd19:   return 64'd63776;
            5'd20:   return 64'd56818;
            5'd21:   return 64'd50612;
            default: return 64'd1;
        endcase
    endfunction

    // Half-period table rescaled (with rounding) to the actual clock at
    // elaboration time; rest entries are never used for toggling.
    logic [18:0] half_tab_s [0:31];
    for (genvar g = 0; g < 32; g++) begin : g_half
        localparam longint SCALED =
            (base_half(5'(g)) * longint'(CLK_HZ) + 64'd50_000_000) / 64'd100_000_000;
        assign half_tab_s[g] = SCALED[18:0];
    end

    logic [1:0]    state_q, state_d;
    logic [4:0]    pitch_q, pitch_d;
    logic          rest_q,  rest_d;
    logic [15:0]   units_q, units_d;
    logic [18:0]   tone_q,  tone_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic          bell_q,  bell_d;
    logic [18:0]   half_last_s;
    logic          tick_wrap_s;
    logic          last_unit_s;

    assign note_ready = (state_q == S_IDLE) & ~rst;
    assign busy       = (state_q != S_IDLE);
    assign bell       = bell_q;
    assign cur_pitch  = pitch_q;

    // Next-state logic for the IDLE / PLAY / GAP sequencer and its counters.
    always_comb begin
        state_d     = state_q;
        pitch_d     = pitch_q;
        rest_d      = rest_q;
        units_d     = units_q;
        tone_d      = tone_q;
        tick_d      = tick_q;
        bell_d      = bell_q;
        half_last_s = half_tab_s[pitch_q] - 19'd1;
        tick_wrap_s = (tick_q == TICK_LAST);
        last_unit_s = (units_q == 16'd1);

        case (state_q)
            S_IDLE: begin
                bell_d = 1'b0;
                // note_ready already folds in rst, and rst wins in the register block.
                if (note_valid) begin
                    state_d = S_PLAY;
                    pitch_d = note_pitch;
                    rest_d  = (note_pitch == 5'd0) || (note_pitch > 5'd21);
                    units_d = (note_len == 4'd0) ? 16'd1 : {12'd0, note_len};
                    tone_d  = 19'd0;
                    tick_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_PLAY: begin
                if (tone_q == half_last_s) begin
                    tone_d = 19'd0;
                    bell_d = ~bell_q & ~rest_q;
                end else begin
                    tone_d = tone_q + 19'd1;
                end

                if (tick_wrap_s) begin
                    tick_d = '0;
                    if (last_unit_s) begin
                        // End of note: silence immediately, whatever the phase.
                        bell_d = 1'b0;
                        tone_d = 19'd0;
                        if (GAP_UNITS == 16'd0) begin
                            state_d = S_IDLE;
                            pitch_d = 5'd0;
                        end else begin
                            state_d = S_GAP;
                            units_d = GAP_UNITS;
                        end
                    end else begin
                        units_d = units_q - 16'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1'b1);
                end
            end

            S_GAP: begin
                bell_d = 1'b0;
                if (tick_wrap_s) begin
                    tick_d = '0;
                    if (last_unit_s) begin
                        state_d = S_IDLE;
                        pitch_d = 5'd0;
                    end else begin
                        units_d = units_q - 16'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1'b1);
                end
            end

            default: begin
                state_d = S_IDLE;
                pitch_d = 5'd0;
                bell_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any note or gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pitch_q <= 5'd0;
            rest_q  <= 1'b0;
            units_q <= 16'd0;
            tone_q  <= 19'd0;
            tick_q  <= '0;
            bell_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pitch_q <= pitch_d;
            rest_q  <= rest_d;
            units_q <= units_d;
            tone_q  <= tone_d;
            tick_q  <= tick_d;
            bell_q  <= bell_d;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player. Two instances run at CLK_HZ = 1 MHz with
// TICK_DIV = 2000: u_a with a one-unit gap, u_b with no gap. At 1 MHz the
// half periods are A4 1136, C4 1911, C5 956, B5 506, C3 3822 cycles.
module tb_note_player;

    localparam int TD = 2000;

    logic       clk;
    logic       rst;
    logic       valid_a, valid_b;
    logic [4:0] pitch;
    logic [3:0] len;
    logic       a_ready, a_bell, a_busy;
    logic [4:0] a_cur;
    logic       b_ready, b_bell, b_busy;
    logic [4:0] b_cur;

    int n_pass;
    int n_total;

    note_player #(.CLK_HZ(1_000_000), .TICK_DIV(TD), .GAP_TICKS(1)) u_a (
        .clk(clk), .rst(rst), .note_valid(valid_a), .note_ready(a_ready),
        .note_pitch(pitch), .note_len(len), .bell(a_bell), .busy(a_busy),
        .cur_pitch(a_cur)
    );

    note_player #(.CLK_HZ(1_000_000), .TICK_DIV(TD), .GAP_TICKS(0)) u_b (
        .clk(clk), .rst(rst), .note_valid(valid_b), .note_ready(b_ready),
        .note_pitch(pitch), .note_len(len), .bell(b_bell), .busy(b_busy),
        .cur_pitch(b_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pitch;
        logic [3:0] len;
        int         half;   // 0 = silent note
        int         play;   // cycles of PLAY
        int         total;  // cycles from acceptance to note_ready
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic sample(input bit sel, output logic r, output logic b, output logic bu,
                          output logic [4:0] c);
        if (sel) begin r = b_ready; b = b_bell; bu = b_busy; c = b_cur; end
        else     begin r = a_ready; b = a_bell; bu = a_busy; c = a_cur; end
    endtask

    // Called at a negedge with the note already presented; the following
    // posedge is the acceptance edge k. Sample t is taken after edge k+t.
    task automatic run_note(input bit sel, input logic [4:0] p, input int half,
                            input int play, input int total, input bit hold,
                            input logic [4:0] np, input logic [3:0] nl, input string tag,
                            output logic [4:0] c_first, output logic [4:0] c_last);
        logic r, b, bu, exp_bell, exp_busy;
        logic [4:0] c;
        int bad_bell, bad_hs, bad_cur, first_bad;
        bad_bell = 0; bad_hs = 0; bad_cur = 0; first_bad = -1;
        c_first = 5'd0; c_last = 5'd0;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            sample(sel, r, b, bu, c);
            if (t == 0) begin
                c_first = c;
                check(bu === 1'b1, {tag, "/accepted"}, int'(bu), 1);
                check(c === p, {tag, "/cur_pitch_latched"}, int'(c), int'(p));
                if (hold) begin
                    pitch = np;
                    len   = nl;
                end else if (sel) begin
                    valid_b = 1'b0;
                end else begin
                    valid_a = 1'b0;
                end
            end
            if (t == total) c_last = c;
            exp_bell = (half == 0 || t >= play) ? 1'b0 : 1'((t / half) % 2);
            exp_busy = (t < total);
            if (b !== exp_bell) begin
                bad_bell++;
                if (first_bad < 0) first_bad = t;
            end
            if (bu !== exp_busy || r !== ~exp_busy) bad_hs++;
            if (c !== (exp_busy ? p : 5'd0)) bad_cur++;
        end
        check(bad_bell == 0, {tag, "/bell_wave_bad_cycles(first_bad_t)"}, first_bad, -1);
        check(bad_hs == 0, {tag, "/busy_ready_bad_cycles"}, bad_hs, 0);
        check(bad_cur == 0, {tag, "/cur_pitch_bad_cycles"}, bad_cur, 0);
    endtask

    initial begin
        logic [4:0] cf, cl;
        logic [4:0] seq [0:5];
        logic [4:0] seq_exp [0:5];
        int waited;

        n_pass = 0;
        n_total = 0;

        vecs[0] = '{pitch: 5'd13, len: 4'd2, half: 1136, play: 4000, total: 6000};
        vecs[1] = '{pitch: 5'd0,  len: 4'd3, half: 0,    play: 6000, total: 8000};
        vecs[2] = '{pitch: 5'd27, len: 4'd1, half: 0,    play: 2000, total: 4000};
        vecs[3] = '{pitch: 5'd15, len: 4'd1, half: 956,  play: 2000, total: 4000};
        vecs[4] = '{pitch: 5'd21, len: 4'd1, half: 506,  play: 2000, total: 4000};
        vecs[5] = '{pitch: 5'd1,  len: 4'd2, half: 3822, play: 4000, total: 6000};

        seq_exp[0] = 5'd1;  seq_exp[1] = 5'd0; seq_exp[2] = 5'd21;
        seq_exp[3] = 5'd0;  seq_exp[4] = 5'd0; seq_exp[5] = 5'd0;

        // Reset held 3 cycles with a note already offered: nothing accepted.
        rst = 1'b1; valid_a = 1'b1; valid_b = 1'b0;
        pitch = vecs[0].pitch; len = vecs[0].len;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(a_ready === 1'b0, "reset/ready_low", int'(a_ready), 0);
            check(a_busy === 1'b0 && a_bell === 1'b0, "reset/idle_silent",
                  int'({a_busy, a_bell}), 0);
        end
        rst = 1'b0;
        #1;
        check(a_ready === 1'b1, "reset/ready_after", int'(a_ready), 1);
        check(a_bell === 1'b0 && a_busy === 1'b0 && a_cur === 5'd0, "reset/outputs",
              int'({a_bell, a_busy, a_cur}), 0);
        check(b_ready === 1'b1, "reset/b_ready_after", int'(b_ready), 1);

        // Table of single notes on the gapped instance.
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                pitch = vecs[i].pitch; len = vecs[i].len; valid_a = 1'b1;
            end
            run_note(1'b0, vecs[i].pitch, vecs[i].half, vecs[i].play, vecs[i].total,
                     1'b0, 5'd0, 4'd0, $sformatf("vec%0d", i), cf, cl);
        end

        // Streaming: note_valid held across three len-1 notes.
        pitch = 5'd1; len = 4'd1; valid_a = 1'b1;
        run_note(1'b0, 5'd1, 3822, 2000, 4000, 1'b1, 5'd21, 4'd1, "stream0", seq[0], seq[1]);
        run_note(1'b0, 5'd21, 506, 2000, 4000, 1'b1, 5'd0, 4'd1, "stream1", seq[2], seq[3]);
        run_note(1'b0, 5'd0, 0, 2000, 4000, 1'b0, 5'd0, 4'd0, "stream2", seq[4], seq[5]);
        for (int i = 0; i < 6; i++)
            check(seq[i] === seq_exp[i], $sformatf("stream/cur_seq%0d", i),
                  int'(seq[i]), int'(seq_exp[i]));
        repeat (3) @(negedge clk);
        check(a_busy === 1'b0 && a_ready === 1'b1, "stream/no_duplicate",
              int'({a_busy, a_ready}), 1);

        // Abort: reset pulse while bell is high.
        pitch = 5'd13; len = 4'd2; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        waited = 0;
        while (a_bell !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check(waited == 1136, "abort/first_rise_cycle", waited, 1136);
        rst = 1'b1;
        @(negedge clk);
        check(a_bell === 1'b0, "abort/bell_cleared", int'(a_bell), 0);
        check(a_busy === 1'b0 && a_cur === 5'd0, "abort/idle", int'({a_busy, a_cur}), 0);
        check(a_ready === 1'b0, "abort/ready_in_reset", int'(a_ready), 0);
        rst = 1'b0;
        #1;
        check(a_ready === 1'b1, "abort/ready_no_gap", int'(a_ready), 1);
        pitch = 5'd13; len = 4'd1; valid_a = 1'b1;
        run_note(1'b0, 5'd13, 1136, 2000, 4000, 1'b0, 5'd0, 4'd0, "after_abort", cf, cl);

        // Len 0 on the gapless instance: one unit of C4, straight back to IDLE.
        pitch = 5'd8; len = 4'd0; valid_b = 1'b1;
        run_note(1'b1, 5'd8, 1911, 2000, 2000, 1'b0, 5'd0, 4'd0, "len0_nogap", cf, cl);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
